// File: rtl/div8_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : div8_seq                                                   |
// | Description : Sequential unsigned restoring divider. A start request     |
// |               latches a (dividend) and b (divisor), runs WIDTH           |
// |               shift-subtract iterations and presents a registered        |
// |               quotient q and remainder r. b == 0 completes immediately   |
// |               with q = all-ones, r = a and dbz set.                      |
// |               Build option DIV8_SEQ_START_EDGE_EN: start is edge-        |
// |               detected (one division per press) instead of level-        |
// |               sensitive.                                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module div8_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             dbz
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_dq;
    logic [WIDTH-1:0]   r_dv;
    logic [WIDTH:0]     r_pr;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_go;
    logic [WIDTH:0]     w_t;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [WIDTH:0]     w_pr_next;
    logic [WIDTH-1:0]   w_dq_next;

    // The partial remainder always stays below the divisor, so its top bit
    // is structurally zero and never consulted.
    logic               w_unused_pr_msb;
    assign w_unused_pr_msb = r_pr[WIDTH];

    // One restoring step: shift in the next dividend bit, subtract if it fits
    assign w_t       = {r_pr[WIDTH-1:0], r_dq[WIDTH-1]};
    assign w_diff    = w_t - {1'b0, r_dv};
    assign w_ge      = (w_t >= {1'b0, r_dv});
    assign w_pr_next = w_ge ? w_diff : w_t;
    assign w_dq_next = {r_dq[WIDTH-2:0], w_ge};

`ifdef DIV8_SEQ_START_EDGE_EN
    logic r_start_d;

    // Delayed copy of start so a held button launches only one division
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start_d <= 1'b0;
        end else begin
            r_start_d <= start;
        end
    end

    assign w_go = start & ~r_start_d & (r_state != S_CALC);
`else
    assign w_go = start & (r_state != S_CALC);
`endif

    // Control FSM, datapath registers and registered result/status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_dq    <= '0;
            r_dv    <= '0;
            r_pr    <= '0;
            r_cnt   <= '0;
            q       <= '0;
            r       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dbz     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_go) begin
                        if (b == '0) begin
                            // Divide-by-zero resolves on the accepting edge
                            q       <= '1;
                            r       <= a;
                            dbz     <= 1'b1;
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_dq    <= a;
                            r_dv    <= b;
                            r_pr    <= '0;
                            r_cnt   <= '0;
                            done    <= 1'b0;
                            dbz     <= 1'b0;
                            busy    <= 1'b1;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_dq  <= w_dq_next;
                    r_pr  <= w_pr_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST_ITER) begin
                        q       <= w_dq_next;
                        r       <= w_pr_next[WIDTH-1:0];
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div8_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_div8_seq                                                |
// | Description : Scoreboard bench for div8_seq. Stimulus pushes expected    |
// |               results (with completion cycle); a monitor pops one entry  |
// |               on every rising edge of done and compares.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_div8_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd0;
    logic [7:0] q;
    logic [7:0] r;
    logic       busy;
    logic       done;
    logic       dbz;

    div8_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: each new completion must match the oldest expectation
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (done && !prev_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("q", q, e.q);
                    check("r", r, e.r);
                    check("dbz", dbz, e.dbz);
                    check("latency_cycle", cyc, e.cyc);
                end
            end
            prev_done = done;
        end
    end

    // One-cycle start pulse; returns at the negedge after the accepting edge
    task automatic launch(input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] eq, input logic [7:0] er,
                          input logic edbz, input int lat);
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        sb.push_back('{eq, er, edbz, cyc + 1 + lat});
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait for done, counting cycles with busy high
    task automatic wait_done(input string name, input int exp_busy);
        int nb;
        bit seen;
        nb = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (busy) nb++;
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        check({name, "_done_seen"}, seen, 1);
        check({name, "_busy_cycles"}, nb, exp_busy);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_q", q, 0);
        check("rst_r", r, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", dbz, 0);
        rst = 1'b0;

        // Basic divisions: 200/7 = 28 r4, 255/1 = 255 r0, 5/9 = 0 r5
        launch(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 8);
        wait_done("d200_7", 8);
        launch(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8);
        wait_done("d255_1", 8);
        launch(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 8);
        wait_done("d5_9", 8);

        // Start pulse during CALC with new operands must be ignored
        launch(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 8);
        @(negedge clk);
        @(negedge clk);
        a = 8'd50;
        b = 8'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore", 5);

        // Reset mid-CALC aborts immediately; nothing resumes
        check("pre_rst_q", q, 28);
        @(negedge clk);
        a = 8'd200;
        b = 8'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("calc_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_q", q, 0);
        check("abort_r", r, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("no_resume_busy", busy, 0);
        check("no_resume_done", done, 0);

        // Divide by zero: result on the accepting edge, busy never set
        launch(8'd37, 8'd0, 8'hFF, 8'd37, 1'b1, 0);
        wait_done("dbz", 0);

        // Hold start for 30 cycles with 100/3 = 33 r1
        @(negedge clk);
        a = 8'd100;
        b = 8'd3;
        start = 1'b1;
`ifdef DIV8_SEQ_START_EDGE_EN
        sb.push_back('{8'd33, 8'd1, 1'b0, cyc + 1 + 8});
`else
        sb.push_back('{8'd33, 8'd1, 1'b0, cyc + 1 + 8});
        sb.push_back('{8'd33, 8'd1, 1'b0, cyc + 1 + 17});
        sb.push_back('{8'd33, 8'd1, 1'b0, cyc + 1 + 26});
        sb.push_back('{8'd33, 8'd1, 1'b0, cyc + 1 + 35});
`endif
        repeat (30) @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("hold_busy_idle", busy, 0);
        check("pending_expectations", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/div8_seq.md
# div8_seq

Sequential 8-bit unsigned restoring divider for the lab board. It is the inverse-arithmetic companion to the registered 8-bit adder. The dividend comes from sw15-8 and the divisor from sw7-0; a button press starts a division. Quotient and remainder are presented on the LEDs after a fixed 8-cycle shift-subtract iteration. Operands are captured in registers at start, so switch movement during a division has no effect.

## Interface
- `WIDTH`, 8: operand and result width. Cycle counts in this document assume 8.
- `clk` input 1: clock (clk100mhz).
- `rst` input 1: reset, asynchronous, active-high (btnu).
- `start` input 1: start request (btnl).
- `a` input WIDTH: dividend (sw15-8).
- `b` input WIDTH: divisor (sw7-0).
- `q` output WIDTH: registered quotient (led7-0).
- `r` output WIDTH: registered remainder (led15-8).
- `busy` output 1: high while iterating.
- `done` output 1: high from completion until the next accepted start.
- `dbz` output 1: divide-by-zero flag for the last division.

## Operation
- The FSM has three states: IDLE, CALC and DONE.
- Internal registers: dividend/quotient shift register `dq` (WIDTH), divisor `dv` (WIDTH), partial remainder `pr` (WIDTH+1), iteration counter `cnt` (3 bits).
- Accepted start (`go`): in IDLE or DONE only. Starts in CALC are ignored.
- `go` with `b != 0`:
  - load `dq<=a`, `dv<=b`, `pr<=0`, `cnt<=0`;
  - clear `done` and `dbz`;
  - go to CALC.
- `go` with `b == 0`:
  - go directly to DONE;
  - `q<=8'hFF`, `r<=a`, `dbz<=1`, `done<=1`.
- One CALC iteration per clock:
  - `t = {pr[WIDTH-1:0], dq[WIDTH-1]}`;
  - if `t >= dv`, then `pr<=t-dv` and the shifted-in quotient bit is 1;
  - otherwise `pr<=t` and the bit is 0;
  - `dq<={dq[WIDTH-2:0], bit}`;
  - `cnt<=cnt+1`.
- Completion, on the iteration where `cnt==7`:
  - `q<=` final `dq`, `r<=` final `pr[WIDTH-1:0]`;
  - `done<=1`;
  - go to DONE.
- `q` and `r` change only on completion or the divide-by-zero path. During CALC they hold the previous result.
- `busy` is 1 exactly when the state is CALC.
- DONE persists until the next `go`. A `go` from DONE behaves exactly as a `go` from IDLE.
- Unsigned arithmetic only. Invariant on completion: `a == q*b + r` and `r < b`.

## Timing
- Reset values:
  - state IDLE;
  - `q=0`, `r=0`;
  - `busy=0`, `done=0`, `dbz=0`;
  - internal registers 0.
- `rst` asserted mid-CALC aborts the division immediately and asynchronously. Nothing resumes after release.
- Let edge E0 be the edge that accepts `go`.
  - Iterations occur on E1..E8.
  - `busy` is high after E0 until E8.
  - `q`, `r` and `done` are valid after E8, so latency is 8 cycles.
- Divide-by-zero: `done`, `dbz`, `q` and `r` are valid after E0, so latency is 0 extra cycles.
- Back-to-back divisions: a new `go` can be accepted on the first cycle in DONE.

## Configuration
- Macro: `DIV8_SEQ_START_EDGE_EN`.
- Defined:
  - `go = start & ~start_d & (state != CALC)`, where `start_d` is a registered copy of `start` with reset value 0;
  - holding btnl yields exactly one division;
  - if `start` is already high when reset is released, one division is started on the first edge.
- Undefined:
  - `go = start & (state != CALC)`, level-sensitive;
  - holding `start` restarts the division on every cycle spent in IDLE or DONE. `done` is then high for one cycle every 9 cycles (b≠0), or `dbz` stays high continuously (b=0).

## Test plan
- a=200, b=7, one-cycle start → `busy` high for 8 cycles, then q=28, r=4, done=1, dbz=0.
- a=255, b=1, and a=5, b=9 → q=255, r=0 and q=0, r=5 respectively, each exactly 8 cycles after start.
- a=37, b=0, start → after the same edge: q=8'hFF, r=37, dbz=1, done=1, busy never asserted.
- Start 200/7, then change a/b and pulse start at cycle 3 of CALC → pulse ignored; result q=28, r=4 still after E8.
- Assert rst at cycle 4 of CALC with previous result q=28 → immediately q=0, r=0, busy=0, done=0, state IDLE.
- Hold start high for 30 cycles with a=100, b=3:
  - macro defined → exactly one completion with q=33, r=1;
  - macro undefined → `done` pulses every 9 cycles.
